// File: rtl/if_fetch_stage.sv
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction-fetch stage for the 16-bit 5-stage pipeline.
//               Owns the fetch PC, keeps at most one request outstanding to a
//               variable-latency instruction memory, and buffers returned
//               words in an output register plus a one-entry skid buffer.
//               Redirects flush all buffered work and discard any in-flight
//               wrong-path response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] PC_STEP   = 16'h0001,
  parameter logic [15:0] NOP_INSTR = 16'h4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] out_pc,
  output logic [15:0] out_instr,
  output logic        out_valid
);

  // IDLE: nothing outstanding, WAIT: request outstanding,
  // DROP: request outstanding whose data must be thrown away.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]  state_q,      state_d;
  logic [15:0] pc_q,         pc_d;
  logic [15:0] drop_addr_q,  drop_addr_d;
  logic        out_valid_q,  out_valid_d;
  logic [15:0] out_pc_q,     out_pc_d;
  logic [15:0] out_instr_q,  out_instr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [15:0] skid_pc_q,    skid_pc_d;
  logic [15:0] skid_instr_q, skid_instr_d;

  logic        w_fire;
  logic        w_accept;
  logic        w_consume;
  logic [15:0] w_entry_pc;

  // Memory request: new requests only start with the skid buffer free, so an
  // accepted response always has somewhere to land.
  always_comb begin
    imem_req  = !rst && (((state_q == ST_IDLE) && !skid_valid_q && !redirect) ||
                         (state_q == ST_WAIT) || (state_q == ST_DROP));
    imem_addr = (state_q == ST_DROP) ? drop_addr_q : pc_q;
  end

  // Next-state computation for the FSM, PC and the output/skid buffers.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    w_fire     = imem_req && imem_ack;
    w_consume  = out_valid_q && !stall;
    w_entry_pc = imem_addr + PC_STEP;
    // A response is kept only when it is on the right path.
    w_accept   = w_fire && (state_q != ST_DROP) && !redirect;

    case (state_q)
      ST_IDLE: begin
        if (imem_req && !imem_ack) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_fire) begin
          state_d = ST_IDLE;
        end else if (redirect) begin
          // Keep presenting the doomed address until the memory answers.
          state_d     = ST_DROP;
          drop_addr_d = pc_q;
        end
      end
      ST_DROP: begin
        if (w_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect) begin
      pc_d         = redirect_pc;
      out_valid_d  = 1'b0;
      out_instr_d  = NOP_INSTR;
      skid_valid_d = 1'b0;
    end else if (w_accept) begin
      pc_d = pc_q + PC_STEP;
      if (!out_valid_q || w_consume) begin
        out_valid_d = 1'b1;
        out_pc_d    = w_entry_pc;
        out_instr_d = imem_rdata;
      end else begin
        skid_valid_d = 1'b1;
        skid_pc_d    = w_entry_pc;
        skid_instr_d = imem_rdata;
      end
    end else if (w_consume) begin
      if (skid_valid_q) begin
        out_pc_d     = skid_pc_q;
        out_instr_d  = skid_instr_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
        out_instr_d = NOP_INSTR;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      drop_addr_q  <= 16'h0000;
      out_valid_q  <= 1'b0;
      out_pc_q     <= 16'h0000;
      out_instr_q  <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 16'h0000;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;

endmodule

`default_nettype wire
